// File: rtl/spi_slave_if.sv
// Mode-0 SPI responder: every SPI pin is oversampled in the clk domain.
// Full-duplex shifting with a single-entry TX buffer and an RX word pulse.
module spi_slave_if #(
  parameter int unsigned              DATA_WIDTH  = 8,
  parameter int unsigned              SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0]    IDLE_TX     = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {WAIT_HIGH, IDLE, SHIFT} state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, cs_sync_q, mosi_sync_q, primed_q;
  logic                    sclk_prev_q, cs_prev_q;
  logic [DATA_WIDTH-1:0]   tx_buf_q, tx_buf_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    overrun_q, overrun_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic load_due;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      primed_q    <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= WAIT_HIGH;
      tx_buf_q    <= '0;
      tx_valid_q  <= 1'b0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      bit_cnt_q   <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      primed_q    <= {primed_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      tx_buf_q    <= tx_buf_d;
      tx_valid_q  <= tx_valid_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_buf_d   = tx_buf_q;
    tx_valid_d = tx_valid_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    overrun_d  = 1'b0;
    bit_cnt_d  = bit_cnt_q;
    load_due   = 1'b0;

    unique case (state_q)
      // The synchronizers reset to cs=1, so only trust cs once they hold post-reset pin samples.
      WAIT_HIGH: begin
        if (primed_q[SYNC_STAGES-1] && cs_s) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          load_due  = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
          if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
            bit_cnt_d  = '0;
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q != '0) tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          else                 load_due   = 1'b1;
        end
      end
      default: state_d = WAIT_HIGH;
    endcase

    if (load_due) begin
      if (tx_valid_q) begin
        tx_shift_d = tx_buf_q;
        tx_valid_d = 1'b0;
      end else begin
        tx_shift_d = IDLE_TX;
        overrun_d  = 1'b1;
      end
    end

    // Consumption only happens from a full buffer, so it never collides with an accepted write.
    if (tx_load && !tx_valid_q) begin
      tx_buf_d   = tx_data;
      tx_valid_d = 1'b1;
    end
  end

  assign miso     = (state_q == SHIFT) ? tx_shift_q[DATA_WIDTH-1] : 1'b0;
  assign tx_ready = ~tx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q == SHIFT);
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a behavioural mode-0 master drives the pins.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, cs, mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, busy, overrun;

  int passed = 0;
  int total  = 0;
  int rx_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] rx_last;

  localparam int HALF = 60;

  spi_slave_if #(.DATA_WIDTH(8), .SYNC_STAGES(2), .IDLE_TX(8'hFF)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt  = rx_cnt + 1;
      rx_last = rx_data;
    end
    if (overrun) ov_cnt = ov_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  // Shifts nbits (MSB first); with last set, cs rises together with the final sclk fall.
  task automatic spi_xfer(input logic [7:0] w, input int nbits, input bit last,
                          output logic [7:0] m);
    logic [7:0] wv;
    wv = w;
    m  = '0;
    for (int k = 0; k < nbits; k++) begin
      mosi = wv[7-k];
      #HALF;
      m[7-k] = miso;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
      if (k == nbits - 1 && last) cs = 1'b1;
    end
  endtask

  task automatic clear_counts();
    rx_cnt = 0;
    ov_cnt = 0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; tx_data = '0; tx_load = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (miso !== 1'b0) $display("FAIL reset_miso got %b exp 0", miso); else passed++;
    total++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready got %b exp 1", tx_ready); else passed++;
    total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h exp 00", rx_data); else passed++;
    total++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b exp 0", rx_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b exp 0", overrun); else passed++;
  endtask

  task automatic test_single();
    logic [7:0] m;
    load_tx(8'h3C);
    total++; if (tx_ready !== 1'b0) $display("FAIL single_ready_after_load got %b exp 0", tx_ready); else passed++;
    clear_counts();
    cs_low();
    total++; if (busy !== 1'b1) $display("FAIL single_busy_in_frame got %b exp 1", busy); else passed++;
    total++; if (tx_ready !== 1'b1) $display("FAIL single_ready_after_csfall got %b exp 1", tx_ready); else passed++;
    spi_xfer(8'hAA, 8, 1'b1, m);
    repeat (10) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL single_busy_after got %b exp 0", busy); else passed++;
    total++; if (rx_cnt !== 1) $display("FAIL single_rx_count got %0d exp 1", rx_cnt); else passed++;
    total++; if (rx_data !== 8'hAA) $display("FAIL single_rx_data got %h exp aa", rx_data); else passed++;
    total++; if (m !== 8'h3C) $display("FAIL single_miso_word got %h exp 3c", m); else passed++;
    total++; if (ov_cnt !== 0) $display("FAIL single_overrun got %0d exp 0", ov_cnt); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] m1, m2;
    logic [7:0] first_rx;
    load_tx(8'h0F);
    clear_counts();
    cs_low();
    fork
      spi_xfer(8'h55, 8, 1'b0, m1);
      begin
        repeat (20) @(negedge clk);
        load_tx(8'hF0);
      end
    join
    first_rx = rx_last;
    spi_xfer(8'h0F, 8, 1'b1, m2);
    repeat (10) @(negedge clk);
    total++; if (rx_cnt !== 2) $display("FAIL b2b_rx_count got %0d exp 2", rx_cnt); else passed++;
    total++; if (first_rx !== 8'h55) $display("FAIL b2b_rx_word0 got %h exp 55", first_rx); else passed++;
    total++; if (rx_last !== 8'h0F) $display("FAIL b2b_rx_word1 got %h exp 0f", rx_last); else passed++;
    total++; if (m1 !== 8'h0F) $display("FAIL b2b_miso_word0 got %h exp 0f", m1); else passed++;
    total++; if (m2 !== 8'hF0) $display("FAIL b2b_miso_word1 got %h exp f0", m2); else passed++;
    total++; if (ov_cnt !== 0) $display("FAIL b2b_overrun got %0d exp 0", ov_cnt); else passed++;
  endtask

  task automatic test_underrun();
    logic [7:0] m;
    clear_counts();
    cs_low();
    total++; if (ov_cnt !== 1) $display("FAIL underrun_at_csfall got %0d exp 1", ov_cnt); else passed++;
    spi_xfer(8'hFF, 8, 1'b1, m);
    repeat (10) @(negedge clk);
    total++; if (ov_cnt !== 1) $display("FAIL underrun_total got %0d exp 1", ov_cnt); else passed++;
    total++; if (m !== 8'hFF) $display("FAIL underrun_miso got %h exp ff", m); else passed++;
    total++; if (rx_data !== 8'hFF) $display("FAIL underrun_rx_data got %h exp ff", rx_data); else passed++;
  endtask

  task automatic test_abort();
    logic [7:0] m;
    clear_counts();
    cs_low();
    spi_xfer(8'h5A, 5, 1'b0, m);
    repeat (6) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (rx_cnt !== 0) $display("FAIL abort_no_valid got %0d exp 0", rx_cnt); else passed++;
    total++; if (rx_data !== 8'hFF) $display("FAIL abort_rx_kept got %h exp ff", rx_data); else passed++;
    cs_low();
    spi_xfer(8'h81, 8, 1'b1, m);
    repeat (10) @(negedge clk);
    total++; if (rx_cnt !== 1) $display("FAIL abort_next_count got %0d exp 1", rx_cnt); else passed++;
    total++; if (rx_data !== 8'h81) $display("FAIL abort_next_data got %h exp 81", rx_data); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] m;
    clear_counts();
    cs_low();
    spi_xfer(8'hE0, 3, 1'b0, m);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", busy); else passed++;
    total++; if (rx_data !== 8'h00) $display("FAIL rstmid_rx_data got %h exp 00", rx_data); else passed++;
    total++; if (miso !== 1'b0) $display("FAIL rstmid_miso got %b exp 0", miso); else passed++;
    total++; if (tx_ready !== 1'b1) $display("FAIL rstmid_tx_ready got %b exp 1", tx_ready); else passed++;
    spi_xfer(8'h3C, 8, 1'b0, m);
    repeat (10) @(negedge clk);
    total++; if (rx_cnt !== 0) $display("FAIL rstmid_no_xfer_count got %0d exp 0", rx_cnt); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_no_xfer_busy got %b exp 0", busy); else passed++;
    cs = 1'b1;
    repeat (10) @(negedge clk);
    cs_low();
    spi_xfer(8'hC3, 8, 1'b1, m);
    repeat (10) @(negedge clk);
    total++; if (rx_cnt !== 1) $display("FAIL rstmid_next_count got %0d exp 1", rx_cnt); else passed++;
    total++; if (rx_data !== 8'hC3) $display("FAIL rstmid_next_data got %h exp c3", rx_data); else passed++;
  endtask

  task automatic test_tx_handshake();
    logic [7:0] m;
    load_tx(8'h11);
    load_tx(8'h22);
    total++; if (tx_ready !== 1'b0) $display("FAIL hs_ready_full got %b exp 0", tx_ready); else passed++;
    clear_counts();
    cs_low();
    spi_xfer(8'h00, 8, 1'b1, m);
    repeat (10) @(negedge clk);
    total++; if (m !== 8'h11) $display("FAIL hs_miso_word got %h exp 11", m); else passed++;
    total++; if (tx_ready !== 1'b1) $display("FAIL hs_ready_after got %b exp 1", tx_ready); else passed++;
    total++; if (ov_cnt !== 0) $display("FAIL hs_overrun got %0d exp 0", ov_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid();
    test_tx_handshake();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
